// File: rtl/cpu_pkg.sv
// cpu_pkg: shared GRF writeback widths and the buffered MDU result entry
package cpu_pkg;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic [REG_AW-1:0] a3;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
        logic              live;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of MDU results with kill-by-address and busy-mask reduction
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  wb_entry_t         push_entry_i,
    input  logic              pop_i,
    input  logic              kill_i,
    input  logic [REG_AW-1:0] kill_a3_i,
    output wb_entry_t         head_o,
    output logic [PTR_W:0]    count_o,
    output logic [DATA_W-1:0] busy_mask_o
);
    wb_entry_t        entries_q [DEPTH];
    wb_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    // kill matching live entries, clear the popped slot, then write the younger incoming result
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < DEPTH; i++)
            if (kill_i && entries_q[i].live && entries_q[i].a3 == kill_a3_i) entries_d[i].live = 1'b0;
        if (pop_i) entries_d[rd_ptr_q].live = 1'b0;
        if (push_i) entries_d[wr_ptr_q] = push_entry_i;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        count_d  = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end
    // buffer state; slots outside the held range always have live cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end
    // one-hot OR of live destinations for the decode stall logic
    always_comb begin
        busy_mask_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (entries_q[i].live) busy_mask_o[entries_q[i].a3] = 1'b1;
        busy_mask_o[0] = 1'b0;
    end
    assign head_o  = entries_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges pipeline writeback and buffered MDU results onto the GRF write port
module grf_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_a3,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [REG_AW-1:0] mdu_a3,
    input  logic [DATA_W-1:0] mdu_data,
    input  logic [DATA_W-1:0] mdu_pc,
    output logic [REG_AW-1:0] A3,
    output logic              WE_op,
    output logic [DATA_W-1:0] WE,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] busy_mask,
    output logic              fifo_empty
);
    wb_entry_t      head;
    logic [PTR_W:0] count;
    logic           wb_win, head_live, head_win, pop, push;
    // WB always wins; a dead head is discarded every cycle, a live one only in an idle slot
    always_comb begin
        wb_win     = reset && wb_valid && wb_a3 != REG_ZERO;
        head_live  = count != '0 && head.live;
        head_win   = reset && !wb_win && head_live;
        pop        = reset && count != '0 && (!head.live || !wb_win);
        mdu_ready  = reset && count != (PTR_W+1)'(DEPTH);
        push       = mdu_valid && mdu_ready && mdu_a3 != REG_ZERO;
        WE_op      = wb_win || head_win;
        A3         = wb_win ? wb_a3 : head_win ? head.a3 : REG_ZERO;
        WE         = wb_win ? wb_data : head_win ? head.data : '0;
        PC         = wb_win ? wb_pc : head_win ? head.pc : '0;
        fifo_empty = count == '0;
    end
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_entry_i('{a3: mdu_a3, data: mdu_data, pc: mdu_pc, live: 1'b1}),
        .pop_i       (pop),
        .kill_i      (wb_win),
        .kill_a3_i   (wb_a3),
        .head_o      (head),
        .count_o     (count),
        .busy_mask_o (busy_mask)
    );
endmodule
